// File: rtl/tx_code_group_pkg.sv
// tx_code_group_pkg: shared 8b/10b table, RD- forms with bits abcdei_fghj from MSB down.
package tx_code_group_pkg;
  localparam logic [7:0] O_D0_0  = 8'h00;
  localparam logic [7:0] O_D1_0  = 8'h01;
  localparam logic [7:0] O_D2_0  = 8'h02;
  localparam logic [7:0] O_D3_0  = 8'h03;
  localparam logic [7:0] O_D2_2  = 8'h42;
  localparam logic [7:0] O_D16_2 = 8'h50;
  localparam logic [7:0] O_D26_4 = 8'h9A;
  localparam logic [7:0] O_D6_5  = 8'hA6;
  localparam logic [7:0] O_D21_5 = 8'hB5;
  localparam logic [7:0] O_D5_6  = 8'hC5;
  localparam logic [7:0] O_K28_5 = 8'hBC;
  localparam logic [7:0] O_K23_7 = 8'hF7;
  localparam logic [7:0] O_K27_7 = 8'hFB;
  localparam logic [7:0] O_K29_7 = 8'hFD;
  localparam logic [7:0] O_K30_7 = 8'hFE;
  localparam logic [9:0] C_D0_0  = 10'b100111_0100;
  localparam logic [9:0] C_D1_0  = 10'b011101_0100;
  localparam logic [9:0] C_D2_0  = 10'b101101_0100;
  localparam logic [9:0] C_D3_0  = 10'b110001_1011;
  localparam logic [9:0] C_D2_2  = 10'b101101_0101;
  localparam logic [9:0] C_D16_2 = 10'b011011_0101;
  localparam logic [9:0] C_D26_4 = 10'b010110_1101;
  localparam logic [9:0] C_D6_5  = 10'b011001_1010;
  localparam logic [9:0] C_D21_5 = 10'b101010_1010;
  localparam logic [9:0] C_D5_6  = 10'b101001_0110;
  localparam logic [9:0] C_K28_5 = 10'b001111_1010;
  localparam logic [9:0] C_K23_7 = 10'b111010_1000;
  localparam logic [9:0] C_K27_7 = 10'b110110_1000;
  localparam logic [9:0] C_K29_7 = 10'b101110_1000;
  localparam logic [9:0] C_K30_7 = 10'b011110_1000;
  function automatic logic flips_rd(input logic [9:0] c);
    return $countones(c) != 5;
  endfunction
endpackage

// File: rtl/code_group_lut.sv
// code_group_lut: maps {is_k, octet} to its RD- code-group and a supported flag.
module code_group_lut
  import tx_code_group_pkg::*;
(
  input  logic       is_k,
  input  logic [7:0] octet,
  output logic [9:0] code,
  output logic       ok
);
  always_comb begin
    code = C_K30_7;
    ok = 1'b1;
    case ({is_k, octet})
      {1'b0, O_D0_0}:  code = C_D0_0;
      {1'b0, O_D1_0}:  code = C_D1_0;
      {1'b0, O_D2_0}:  code = C_D2_0;
      {1'b0, O_D3_0}:  code = C_D3_0;
      {1'b0, O_D2_2}:  code = C_D2_2;
      {1'b0, O_D16_2}: code = C_D16_2;
      {1'b0, O_D26_4}: code = C_D26_4;
      {1'b0, O_D6_5}:  code = C_D6_5;
      {1'b0, O_D21_5}: code = C_D21_5;
      {1'b0, O_D5_6}:  code = C_D5_6;
      {1'b1, O_K28_5}: code = C_K28_5;
      {1'b1, O_K23_7}: code = C_K23_7;
      {1'b1, O_K27_7}: code = C_K27_7;
      {1'b1, O_K29_7}: code = C_K29_7;
      {1'b1, O_K30_7}: code = C_K30_7;
      default:         ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/tx_code_group.sv
// tx_code_group: PCS transmit code-group generator for idle, start, data and end sequences.
module tx_code_group
  import tx_code_group_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic [7:0] TXD,
  output logic [9:0] PUDI_TX,
  output logic       TX_EVEN,
  output logic       TX_RD_POS,
  output logic       TX_INVALID
);
  typedef enum logic [2:0] {IDLE_K, IDLE_D, START, DATA, END_T, END_R1, END_R2} state_t;
  state_t     cur, nxt;
  logic       sym_k, lut_ok, bad;
  logic [7:0] sym;
  logic [9:0] lut_code, code;
  always_comb begin
    nxt = IDLE_K;
    case (cur)
      IDLE_K:      nxt = IDLE_D;
      IDLE_D:      nxt = TX_EN ? START : IDLE_K;
      START, DATA: nxt = TX_EN ? DATA : END_T;
      END_T:       nxt = END_R1;
      END_R1:      nxt = TX_EVEN ? END_R2 : IDLE_K;
      default:     nxt = IDLE_K;
    endcase
  end
  // RD positive after K28.5 means it started negative, so D16.2 is needed to bring it back.
  always_comb begin
    sym_k = nxt != IDLE_D && nxt != DATA;
    sym = nxt == IDLE_K ? O_K28_5 :
          nxt == IDLE_D ? (TX_RD_POS ? O_D16_2 : O_D5_6) :
          nxt == START  ? O_K27_7 :
          nxt == DATA   ? TXD :
          nxt == END_T  ? O_K29_7 : O_K23_7;
    bad = nxt == DATA && !lut_ok;
    code = bad ? C_K30_7 : lut_code;
  end
  code_group_lut u_lut (
    .is_k  (sym_k),
    .octet (sym),
    .code  (lut_code),
    .ok    (lut_ok)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE_K;
      PUDI_TX <= C_K28_5;
      TX_EVEN <= 1'b1;
      TX_RD_POS <= 1'b1;
      TX_INVALID <= 1'b0;
    end else begin
      cur <= nxt;
      PUDI_TX <= TX_RD_POS ? ~code : code;
      TX_EVEN <= ~TX_EVEN;
      TX_RD_POS <= TX_RD_POS ^ flips_rd(code);
      TX_INVALID <= bad;
    end
  end
endmodule
